// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port instruction/data memory between the multicycle CPU
// core (fetch/load/store) and a debug/program-loader port. Each access runs
// IDLE -> ACCESS (MEM_LAT cycles) -> RESP (1 cycle) -> IDLE. When both sides
// request in the same IDLE cycle, the side that did not own the previous
// transaction wins. The losing requester simply keeps its request high and is
// served in the next IDLE.
//
// Optional feature macro: DBG_LOCK_EN
//   defined   : adds input i_dbg_lock. While it is high in IDLE only the debug
//               port can be granted; CPU requests are ignored.
//   undefined : no i_dbg_lock port, plain round-robin.
//
// Parameters
//   ADDR_W   address width, passed to memory unchanged
//   DATA_W   data width
//   MEM_LAT  memory read latency in ACCESS cycles (>= 1)
//
// Ports
//   i_clk        system clock, rising edge
//   i_reset      synchronous, active-low reset
//   i_cpu_req    CPU request (level, held until o_cpu_ack)
//   i_cpu_we     1 = store, 0 = read/fetch
//   i_cpu_addr   CPU byte address
//   i_cpu_wdata  CPU store data
//   o_cpu_rdata  CPU read data, registered, held until the next CPU read
//   o_cpu_ack    one-cycle CPU completion pulse
//   i_dbg_*      / o_dbg_*  same as the CPU ports, for the debug port
//   i_dbg_lock   (DBG_LOCK_EN only) restrict grants to the debug port
//   o_mem_addr   address to memory
//   o_mem_wdata  write data to memory
//   o_mem_read   memory read strobe
//   o_mem_write  memory write strobe
//   i_mem_rdata  memory read data
//   o_owner      current grant: 00 none, 01 CPU, 10 debug
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no transaction; sample requests and pick a winner
// S_ACCESS | memory access for the latched requester, MEM_LAT cycles
// S_RESP   | ack pulse to the latched requester, then back to IDLE
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  // CPU port
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_ack,
  // debug / program-loader port
  input  logic              i_dbg_req,
  input  logic              i_dbg_we,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_wdata,
  output logic [DATA_W-1:0] o_dbg_rdata,
  output logic              o_dbg_ack,
`ifdef DBG_LOCK_EN
  input  logic              i_dbg_lock,
`endif
  // memory side
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_read,
  output logic              o_mem_write,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [1:0]        o_owner
);

  // Wide enough to hold MEM_LAT itself; the counter is loaded with MEM_LAT
  // and the last ACCESS cycle is the one where it reads 1.
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_DBG  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [CNT_W-1:0]    r_cnt;
  logic [1:0]          r_grant;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_last_dbg;
  logic [DATA_W-1:0]   r_cpu_rdata;
  logic [DATA_W-1:0]   r_dbg_rdata;
  logic                r_cpu_ack;
  logic                r_dbg_ack;

  logic                w_lock;
  logic                w_grant_cpu;
  logic                w_grant_dbg;
  logic                w_grant_any;
  logic                w_last_access;
  logic                w_first_access;

`ifdef DBG_LOCK_EN
  assign w_lock = i_dbg_lock;
`else
  assign w_lock = 1'b0;
`endif

  // Winner selection for the current IDLE cycle. Under lock the CPU request
  // is masked completely, so the FSM stays idle if only the CPU asks.
  always_comb begin
    w_grant_cpu = 1'b0;
    w_grant_dbg = 1'b0;
    if (w_lock) begin
      w_grant_dbg = i_dbg_req;
    end else if (i_cpu_req && i_dbg_req) begin
      // tie: whoever did not own the previous transaction
      if (r_last_dbg) begin
        w_grant_cpu = 1'b1;
      end else begin
        w_grant_dbg = 1'b1;
      end
    end else begin
      w_grant_cpu = i_cpu_req;
      w_grant_dbg = i_dbg_req;
    end
  end

  assign w_grant_any    = w_grant_cpu | w_grant_dbg;
  assign w_last_access  = (r_cnt == CNT_W'(1));
  assign w_first_access = (r_cnt == CNT_W'(MEM_LAT));

  // state register
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_any) begin
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (w_last_access) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Transaction latch, latency counter, read-data and ack registers.
  // A reset in ACCESS discards the transaction: the ack reg never gets set.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cnt       <= '0;
      r_grant     <= OWN_NONE;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_last_dbg  <= 1'b1;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
      r_cpu_ack   <= 1'b0;
      r_dbg_ack   <= 1'b0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_dbg_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_any) begin
            r_cnt   <= CNT_W'(MEM_LAT);
            r_grant <= w_grant_cpu ? OWN_CPU : OWN_DBG;
            r_we    <= w_grant_cpu ? i_cpu_we    : i_dbg_we;
            r_addr  <= w_grant_cpu ? i_cpu_addr  : i_dbg_addr;
            r_wdata <= w_grant_cpu ? i_cpu_wdata : i_dbg_wdata;
          end
        end
        S_ACCESS: begin
          if (w_last_access) begin
            r_cnt      <= '0;
            r_last_dbg <= (r_grant == OWN_DBG);
            if (r_grant == OWN_CPU) begin
              r_cpu_ack <= 1'b1;
              if (!r_we) begin
                r_cpu_rdata <= i_mem_rdata;
              end
            end else begin
              r_dbg_ack <= 1'b1;
              if (!r_we) begin
                r_dbg_rdata <= i_mem_rdata;
              end
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode, from registered state only (no path from the request
  // inputs). The write strobe is limited to the first ACCESS cycle so a
  // multi-cycle access writes memory exactly once.
  always_comb begin
    o_owner     = OWN_NONE;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    case (r_state)
      S_ACCESS: begin
        o_owner     = r_grant;
        o_mem_addr  = r_addr;
        o_mem_wdata = r_wdata;
        o_mem_read  = ~r_we;
        o_mem_write = r_we & w_first_access;
      end
      S_RESP: begin
        o_owner = r_grant;
      end
      default: begin
      end
    endcase
  end

  assign o_cpu_rdata = r_cpu_rdata;
  assign o_dbg_rdata = r_dbg_rdata;
  assign o_cpu_ack   = r_cpu_ack;
  assign o_dbg_ack   = r_dbg_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances, MEM_LAT=1 (index 0) and
// MEM_LAT=3 (index 1), each with its own combinational-read memory.
// Expected completions are queued when a request is driven and popped when
// the matching ack appears.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]  rst_n;
  logic [1:0]  cpu_req, cpu_we, cpu_ack, dbg_req, dbg_we, dbg_ack;
  logic [1:0]  mem_read, mem_write;
  logic [31:0] cpu_addr [2];
  logic [31:0] cpu_wdata [2];
  logic [31:0] cpu_rdata [2];
  logic [31:0] dbg_addr [2];
  logic [31:0] dbg_wdata [2];
  logic [31:0] dbg_rdata [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic [1:0]  owner [2];
`ifdef DBG_LOCK_EN
  logic [1:0]  dbg_lock;
`endif

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut_l1 (
    .i_clk(clk), .i_reset(rst_n[0]),
    .i_cpu_req(cpu_req[0]), .i_cpu_we(cpu_we[0]), .i_cpu_addr(cpu_addr[0]),
    .i_cpu_wdata(cpu_wdata[0]), .o_cpu_rdata(cpu_rdata[0]), .o_cpu_ack(cpu_ack[0]),
    .i_dbg_req(dbg_req[0]), .i_dbg_we(dbg_we[0]), .i_dbg_addr(dbg_addr[0]),
    .i_dbg_wdata(dbg_wdata[0]), .o_dbg_rdata(dbg_rdata[0]), .o_dbg_ack(dbg_ack[0]),
`ifdef DBG_LOCK_EN
    .i_dbg_lock(dbg_lock[0]),
`endif
    .o_mem_addr(mem_addr[0]), .o_mem_wdata(mem_wdata[0]), .o_mem_read(mem_read[0]),
    .o_mem_write(mem_write[0]), .i_mem_rdata(mem_rdata[0]), .o_owner(owner[0])
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut_l3 (
    .i_clk(clk), .i_reset(rst_n[1]),
    .i_cpu_req(cpu_req[1]), .i_cpu_we(cpu_we[1]), .i_cpu_addr(cpu_addr[1]),
    .i_cpu_wdata(cpu_wdata[1]), .o_cpu_rdata(cpu_rdata[1]), .o_cpu_ack(cpu_ack[1]),
    .i_dbg_req(dbg_req[1]), .i_dbg_we(dbg_we[1]), .i_dbg_addr(dbg_addr[1]),
    .i_dbg_wdata(dbg_wdata[1]), .o_dbg_rdata(dbg_rdata[1]), .o_dbg_ack(dbg_ack[1]),
`ifdef DBG_LOCK_EN
    .i_dbg_lock(dbg_lock[1]),
`endif
    .o_mem_addr(mem_addr[1]), .o_mem_wdata(mem_wdata[1]), .o_mem_read(mem_read[1]),
    .o_mem_write(mem_write[1]), .i_mem_rdata(mem_rdata[1]), .o_owner(owner[1])
  );

  // memories: synchronous write, combinational read, plus a preload path
  logic [31:0] mem [2][256];
  logic        bd_en = 1'b0;
  int          bd_k = 0;
  logic [7:0]  bd_addr = 8'h00;
  logic [31:0] bd_data = 32'h0;

  always @(posedge clk) begin
    if (bd_en) mem[bd_k][bd_addr] <= bd_data;
    for (int k = 0; k < 2; k++) begin
      if (mem_write[k]) mem[k][mem_addr[k][7:0]] <= mem_wdata[k];
    end
  end
  assign mem_rdata[0] = mem[0][mem_addr[0][7:0]];
  assign mem_rdata[1] = mem[1][mem_addr[1][7:0]];

  // reference model
  logic [31:0] model [2][256];
  logic [31:0] exp_rd [2][2];
  bit          model_last_dbg [2];

  typedef struct {
    bit          dbg;
    logic [31:0] rdata;
    int          t_issue;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int rr_prev = -1;

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int k, input logic [7:0] a, input logic [31:0] d);
    bd_en = 1'b1; bd_k = k; bd_addr = a; bd_data = d;
    model[k][a] = d;
    tick();
    bd_en = 1'b0;
  endtask

  function automatic void push_exp(input int k, input bit dbg, input bit we,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input int t_issue);
    exp_t e;
    e.dbg = dbg;
    e.t_issue = t_issue;
    if (we) begin
      model[k][addr[7:0]] = wdata;
      e.rdata = exp_rd[k][int'(dbg)];
    end else begin
      e.rdata = model[k][addr[7:0]];
      exp_rd[k][int'(dbg)] = e.rdata;
    end
    model_last_dbg[k] = dbg;
    sb.push_back(e);
  endfunction

  // round-robin / lock model for a cycle where both sides request
  function automatic bit rr_pick(input int k, input bit lock);
    return lock ? 1'b1 : !model_last_dbg[k];
  endfunction

  task automatic chk_zero(input int k);
    chk("rst_owner", 32'(owner[k]), 32'h0);
    chk("rst_cpu_ack", 32'(cpu_ack[k]), 32'h0);
    chk("rst_dbg_ack", 32'(dbg_ack[k]), 32'h0);
    chk("rst_mem_read", 32'(mem_read[k]), 32'h0);
    chk("rst_mem_write", 32'(mem_write[k]), 32'h0);
    chk("rst_mem_addr", mem_addr[k], 32'h0);
    chk("rst_mem_wdata", mem_wdata[k], 32'h0);
    chk("rst_cpu_rdata", cpu_rdata[k], 32'h0);
    chk("rst_dbg_rdata", dbg_rdata[k], 32'h0);
  endtask

  task automatic wait_ack(input int k, input int budget, input logic [1:0] drop);
    int n;
    exp_t e;
    n = 0;
    while (cpu_ack[k] == 1'b0 && dbg_ack[k] == 1'b0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL sb_underflow: observed=0 entries expected=1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("ack_who", {30'h0, dbg_ack[k], cpu_ack[k]}, e.dbg ? 32'h2 : 32'h1);
      chk("ack_rdata", e.dbg ? dbg_rdata[k] : cpu_rdata[k], e.rdata);
      if (e.t_issue >= 0) chk("ack_latency", 32'(cyc - e.t_issue), 32'(lat(k) + 1));
    end
    if (drop[0]) cpu_req[k] = 1'b0;
    if (drop[1]) dbg_req[k] = 1'b0;
    tick();
    chk("ack_pulse", {30'h0, dbg_ack[k], cpu_ack[k]}, 32'h0);
  endtask

  // single-requester transaction, issued in an IDLE cycle
  task automatic do_txn(input int k, input bit dbg, input bit we,
                        input logic [31:0] addr, input logic [31:0] wdata);
    push_exp(k, dbg, we, addr, wdata, cyc);
    if (dbg) begin
      dbg_req[k] = 1'b1; dbg_we[k] = we; dbg_addr[k] = addr; dbg_wdata[k] = wdata;
    end else begin
      cpu_req[k] = 1'b1; cpu_we[k] = we; cpu_addr[k] = addr; cpu_wdata[k] = wdata;
    end
    tick();
    chk("acc_owner", 32'(owner[k]), dbg ? 32'h2 : 32'h1);
    chk("acc_addr", mem_addr[k], addr);
    chk("acc_read", 32'(mem_read[k]), 32'(!we));
    chk("acc_write", 32'(mem_write[k]), 32'(we));
    if (we) chk("acc_wdata", mem_wdata[k], wdata);
    for (int j = 1; j < lat(k); j++) begin
      tick();
      chk("acc_hold_write", 32'(mem_write[k]), 32'h0);
      chk("acc_hold_read", 32'(mem_read[k]), 32'(!we));
    end
    wait_ack(k, 4, dbg ? 2'b10 : 2'b01);
  endtask

  // contended transaction: both requests held, owner and period checked
  task automatic rr_txn(input int k, input bit exp_dbg, input logic [1:0] drop);
    int n;
    n = 0;
    while (owner[k] == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    chk("rr_owner", 32'(owner[k]), exp_dbg ? 32'h2 : 32'h1);
    chk("rr_period", 32'(cyc - rr_prev), 32'(lat(k) + 2));
    rr_prev = cyc;
    wait_ack(k, 8, drop);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit w;
    rst_n = 2'b00;
    cpu_req = 2'b11; dbg_req = 2'b11;
    cpu_we = 2'b00; dbg_we = 2'b00;
`ifdef DBG_LOCK_EN
    dbg_lock = 2'b00;
`endif
    for (int k = 0; k < 2; k++) begin
      cpu_addr[k] = 32'h0; cpu_wdata[k] = 32'h0;
      dbg_addr[k] = 32'h4; dbg_wdata[k] = 32'h0;
      exp_rd[k][0] = 32'h0; exp_rd[k][1] = 32'h0;
      model_last_dbg[k] = 1'b1;
    end

    // reset held with both requests high (preload runs meanwhile)
    preload(0, 8'h00, 32'h1111_1111);
    preload(0, 8'h04, 32'h2222_2222);
    preload(0, 8'h10, 32'hDEAD_BEEF);
    preload(1, 8'h30, 32'hCAFE_F00D);
    chk_zero(0);
    chk_zero(1);

    // release: instance 0 keeps both requests for four round-robin grants
    cpu_req[1] = 1'b0; dbg_req[1] = 1'b0;
    rst_n = 2'b11;
    // first grant must show up in the cycle right after release
    rr_prev = cyc + 1 - (lat(0) + 2);
    for (int i = 0; i < 4; i++) begin
      w = rr_pick(0, 1'b0);
      push_exp(0, w, 1'b0, w ? 32'h4 : 32'h0, 32'h0, -1);
    end
    chk("rr_first_is_cpu", 32'(sb[0].dbg), 32'h0);
    for (int i = 0; i < 4; i++) begin
      w = sb[0].dbg;
      rr_txn(0, w, (i == 3) ? 2'b11 : 2'b00);
    end

    // MEM_LAT=1 CPU read
    do_txn(0, 1'b0, 1'b0, 32'h10, 32'h0);

    // MEM_LAT=3 debug write, then CPU read-back of the same word
    do_txn(1, 1'b1, 1'b1, 32'h20, 32'h0000_0055);
    do_txn(1, 1'b0, 1'b0, 32'h20, 32'h0);

    // reset during the 2nd ACCESS cycle of a MEM_LAT=3 CPU read
    cpu_req[1] = 1'b1; cpu_we[1] = 1'b0; cpu_addr[1] = 32'h30;
    tick();
    chk("abort_acc1_read", 32'(mem_read[1]), 32'h1);
    tick();
    rst_n[1] = 1'b0;
    cpu_req[1] = 1'b0;
    tick();
    chk_zero(1);
    rst_n[1] = 1'b1;
    exp_rd[1][0] = 32'h0; exp_rd[1][1] = 32'h0;
    model_last_dbg[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_ack", {30'h0, dbg_ack[1], cpu_ack[1]}, 32'h0);
      chk("abort_no_strobe", {30'h0, mem_write[1], mem_read[1]}, 32'h0);
    end
    do_txn(1, 1'b0, 1'b0, 32'h30, 32'h0);

`ifdef DBG_LOCK_EN
    // debug lock: three debug grants while CPU waits, then CPU on release
    dbg_lock[0] = 1'b1;
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 32'h0;
    dbg_req[0] = 1'b1; dbg_we[0] = 1'b0; dbg_addr[0] = 32'h4;
    rr_prev = cyc + 1 - (lat(0) + 2);
    for (int i = 0; i < 3; i++) begin
      w = rr_pick(0, 1'b1);
      push_exp(0, w, 1'b0, w ? 32'h4 : 32'h0, 32'h0, -1);
    end
    for (int i = 0; i < 3; i++) rr_txn(0, 1'b1, 2'b00);
    dbg_lock[0] = 1'b0;
    w = rr_pick(0, 1'b0);
    push_exp(0, w, 1'b0, w ? 32'h4 : 32'h0, 32'h0, -1);
    rr_txn(0, w, 2'b11);
    chk("lock_release_cpu", 32'(w), 32'h0);

    // locked with only the CPU asking: nothing is granted
    dbg_lock[0] = 1'b1;
    cpu_req[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lock_cpu_ignored", 32'(owner[0]), 32'h0);
    end
    cpu_req[0] = 1'b0;
    dbg_lock[0] = 1'b0;
    tick();
`endif

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
